// File: rtl/boe_feeder.sv
// Transmit side of the BOE input interface: batches upstream elements into
// ping-pong banks and serialises each batch onto data_num/data_in with a result gap.
module boe_feeder #(
    parameter int GAP_CYC = 2,
    parameter int DW      = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_valid,
    input  logic [DW-1:0] wr_data,
    input  logic          wr_last,
    output logic          wr_ready,
    output logic [2:0]    data_num,
    output logic [DW-1:0] data_in,
    output logic          busy,
    output logic          batch_done
);

    typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_READY, B_SENDING} bank_state_t;
    typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} tx_state_t;

    // Gap counter must hold N+GAP_CYC-1 for the largest batch (N=7).
    localparam int GW = $clog2(7 + GAP_CYC + 1);

    logic [DW-1:0] r_mem [2][7];
    logic [2:0]    r_cnt [2];
    bank_state_t   r_bank [2];
    logic          r_fill_ptr;
    logic [2:0]    r_fill_cnt;
    logic          r_tx_ptr;
    tx_state_t     r_state;
    logic [2:0]    r_idx;
    logic [GW-1:0] r_gap_cnt;

    logic          r_wr_ready;
    logic [2:0]    r_data_num;
    logic [DW-1:0] r_data_in;
    logic          r_busy;
    logic          r_batch_done;

    logic          w_accept;
    logic          w_commit;
    logic          w_start;
    logic [GW-1:0] w_gap_load;
    bank_state_t   w_bank_nxt [2];
    logic          w_fill_ptr_nxt;
    logic [2:0]    w_fill_cnt_nxt;
    logic          w_tx_ptr_nxt;
    tx_state_t     w_state_nxt;
    logic [2:0]    w_idx_nxt;
    logic [GW-1:0] w_gap_nxt;

    logic          w_wr_ready_nxt;
    logic [2:0]    w_data_num_nxt;
    logic [DW-1:0] w_data_in_nxt;
    logic          w_busy_nxt;
    logic          w_batch_done_nxt;

    // wr_ready is registered from the pre-edge bank state, so a bank freed on
    // this edge cannot also accept a write on this edge.
    assign w_accept   = wr_valid && r_wr_ready;
    assign w_commit   = w_accept && (wr_last || (r_fill_cnt == 3'd6));
    assign w_gap_load = GW'(int'(r_cnt[r_tx_ptr]) + GAP_CYC - 1);

    // Next-state logic for both the write side and the TX FSM.
    always_comb begin : next_state
        // NOTE: every comb output gets a default first so no path infers a latch.
        w_bank_nxt     = r_bank;
        w_fill_ptr_nxt = r_fill_ptr;
        w_fill_cnt_nxt = r_fill_cnt;
        w_tx_ptr_nxt   = r_tx_ptr;
        w_state_nxt    = r_state;
        w_idx_nxt      = r_idx;
        w_gap_nxt      = r_gap_cnt;
        w_start        = 1'b0;

        if (w_accept) begin
            if (w_commit) begin
                w_bank_nxt[r_fill_ptr] = B_READY;
                w_fill_ptr_nxt         = ~r_fill_ptr;
                w_fill_cnt_nxt         = 3'd0;
            end else begin
                w_bank_nxt[r_fill_ptr] = B_FILLING;
                w_fill_cnt_nxt         = r_fill_cnt + 3'd1;
            end
        end

        case (r_state)
            S_IDLE: begin
                if (r_bank[r_tx_ptr] == B_READY) w_start = 1'b1;
            end
            S_SEND: begin
                if (r_idx == r_cnt[r_tx_ptr]) begin
                    w_bank_nxt[r_tx_ptr] = B_EMPTY;
                    w_tx_ptr_nxt         = ~r_tx_ptr;
                    w_state_nxt          = S_GAP;
                    w_gap_nxt            = w_gap_load;
                end else begin
                    w_idx_nxt = r_idx + 3'd1;
                end
            end
            S_GAP: begin
                if (r_gap_cnt == '0) begin
                    if (r_bank[r_tx_ptr] == B_READY) w_start = 1'b1;
                    else                             w_state_nxt = S_IDLE;
                end else begin
                    w_gap_nxt = r_gap_cnt - 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // Commit and transmit always target different banks, so this cannot clash.
        if (w_start) begin
            w_bank_nxt[r_tx_ptr] = B_SENDING;
            w_state_nxt          = S_SEND;
            w_idx_nxt            = 3'd1;
        end
    end

    // Next values of the registered outputs.
    always_comb begin : output_decode
        w_data_num_nxt = '0;
        w_data_in_nxt  = '0;
        if (w_start) begin
            w_data_num_nxt = r_cnt[r_tx_ptr];
            w_data_in_nxt  = r_mem[r_tx_ptr][0];
        end else if (r_state == S_SEND && w_state_nxt == S_SEND) begin
            w_data_in_nxt = r_mem[r_tx_ptr][r_idx];
        end
        w_batch_done_nxt = (w_state_nxt == S_GAP) && (w_gap_nxt == '0);
        w_busy_nxt       = (w_state_nxt != S_IDLE)
                        || (w_bank_nxt[0] == B_READY) || (w_bank_nxt[0] == B_FILLING)
                        || (w_bank_nxt[1] == B_READY) || (w_bank_nxt[1] == B_FILLING);
        w_wr_ready_nxt   = (w_bank_nxt[w_fill_ptr_nxt] == B_EMPTY)
                        || (w_bank_nxt[w_fill_ptr_nxt] == B_FILLING);
    end

    always_ff @(posedge clk) begin : state_reg
        if (rst) begin
            r_bank[0]    <= B_EMPTY;
            r_bank[1]    <= B_EMPTY;
            r_cnt[0]     <= 3'd0;
            r_cnt[1]     <= 3'd0;
            r_fill_ptr   <= 1'b0;
            r_fill_cnt   <= 3'd0;
            r_tx_ptr     <= 1'b0;
            r_state      <= S_IDLE;
            r_idx        <= 3'd0;
            r_gap_cnt    <= '0;
            r_wr_ready   <= 1'b1;
            r_data_num   <= 3'd0;
            r_data_in    <= '0;
            r_busy       <= 1'b0;
            r_batch_done <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            r_bank       <= w_bank_nxt;
            r_fill_ptr   <= w_fill_ptr_nxt;
            r_fill_cnt   <= w_fill_cnt_nxt;
            r_tx_ptr     <= w_tx_ptr_nxt;
            r_state      <= w_state_nxt;
            r_idx        <= w_idx_nxt;
            r_gap_cnt    <= w_gap_nxt;
            r_wr_ready   <= w_wr_ready_nxt;
            r_data_num   <= w_data_num_nxt;
            r_data_in    <= w_data_in_nxt;
            r_busy       <= w_busy_nxt;
            r_batch_done <= w_batch_done_nxt;
            if (w_commit) r_cnt[r_fill_ptr] <= r_fill_cnt + 3'd1;
        end
    end

    // NOTE: element storage has no reset; bank state alone decides what is valid.
    always_ff @(posedge clk) begin : bank_write
        if (w_accept) r_mem[r_fill_ptr][r_fill_cnt] <= wr_data;
    end

    assign wr_ready   = r_wr_ready;
    assign data_num   = r_data_num;
    assign data_in    = r_data_in;
    assign busy       = r_busy;
    assign batch_done = r_batch_done;

endmodule

// File: tb/tb_boe_feeder.sv
// Directed bench for boe_feeder: default instance plus a GAP_CYC=0 instance,
// per-cycle bus traces compared against hand-built expected tables.
module tb_boe_feeder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_valid = 1'b0;
    logic [7:0] wr_data = 8'd0;
    logic       wr_last = 1'b0;

    logic       wr_ready, busy, batch_done;
    logic [2:0] data_num;
    logic [7:0] data_in;
    logic       g0_wr_ready, g0_busy, g0_batch_done;
    logic [2:0] g0_data_num;
    logic [7:0] g0_data_in;

    int n_checks = 0;
    int n_errors = 0;

    // Per-cycle captures, index k = k-th edge after the scenario starts.
    logic [11:0] e_bus [64];
    logic [11:0] o_bus [64];
    logic [11:0] g_bus [64];
    logic        o_rdy [64];
    logic        o_busy [64];
    logic        g_busy [64];

    boe_feeder #(.GAP_CYC(2), .DW(8)) u_dut (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_data(wr_data), .wr_last(wr_last),
        .wr_ready(wr_ready), .data_num(data_num), .data_in(data_in),
        .busy(busy), .batch_done(batch_done)
    );

    boe_feeder #(.GAP_CYC(0), .DW(8)) u_dut_g0 (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_data(wr_data), .wr_last(wr_last),
        .wr_ready(g0_wr_ready), .data_num(g0_data_num), .data_in(g0_data_in),
        .busy(g0_busy), .batch_done(g0_batch_done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; wr_valid = 1'b0; wr_last = 1'b0; wr_data = 8'd0;
        step();
        rst = 1'b0;
    endtask

    task automatic write_elem(input logic [7:0] d, input logic last);
        logic acc;
        int   budget;
        wr_valid = 1'b1; wr_data = d; wr_last = last; budget = 0;
        do begin
            acc = wr_ready;
            step();
            budget++;
        end while (!acc && budget < 50);
        if (!acc) begin
            n_checks++; n_errors++;
            $display("FAIL write_timeout data=%0d not accepted within %0d cycles", d, budget);
        end
        wr_valid = 1'b0; wr_last = 1'b0; wr_data = 8'd0;
    endtask

    task automatic capture(input int n);
        for (int k = 1; k <= n; k++) begin
            step();
            o_bus[k]  = {data_num, data_in, batch_done};
            o_rdy[k]  = wr_ready;
            o_busy[k] = busy;
            g_bus[k]  = {g0_data_num, g0_data_in, g0_batch_done};
            g_busy[k] = g0_busy;
        end
    endtask

    task automatic clear_exp();
        for (int k = 0; k < 64; k++) e_bus[k] = 12'h000;
    endtask

    task automatic set_exp(input int k, input logic [2:0] n, input logic [7:0] d, input logic done);
        e_bus[k] = {n, d, done};
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (data_num !== 3'd0)   begin n_errors++; $display("FAIL reset_data_num got=%0d want=0", data_num); end
        n_checks++; if (data_in !== 8'd0)    begin n_errors++; $display("FAIL reset_data_in got=%0d want=0", data_in); end
        n_checks++; if (busy !== 1'b0)       begin n_errors++; $display("FAIL reset_busy got=%b want=0", busy); end
        n_checks++; if (batch_done !== 1'b0) begin n_errors++; $display("FAIL reset_batch_done got=%b want=0", batch_done); end
        n_checks++; if (wr_ready !== 1'b1)   begin n_errors++; $display("FAIL reset_wr_ready got=%b want=1", wr_ready); end
    endtask

    task automatic test_single();
        do_reset();
        clear_exp();
        set_exp(4, 3'd3, 8'd10, 1'b0);
        set_exp(5, 3'd0, 8'd20, 1'b0);
        set_exp(6, 3'd0, 8'd30, 1'b0);
        set_exp(11, 3'd0, 8'd0, 1'b1);
        fork
            capture(13);
            begin
                write_elem(8'd10, 1'b0);
                write_elem(8'd20, 1'b0);
                write_elem(8'd30, 1'b1);
            end
        join
        for (int k = 1; k <= 13; k++) begin
            n_checks++;
            if (o_bus[k] !== e_bus[k]) begin
                n_errors++;
                $display("FAIL single_bus cycle=%0d got=%03h want=%03h (num,din,done)", k, o_bus[k], e_bus[k]);
            end
        end
        n_checks++; if (o_busy[1] !== 1'b1)  begin n_errors++; $display("FAIL single_busy_fill got=%b want=1", o_busy[1]); end
        n_checks++; if (o_busy[11] !== 1'b1) begin n_errors++; $display("FAIL single_busy_gap got=%b want=1", o_busy[11]); end
        n_checks++; if (o_busy[12] !== 1'b0) begin n_errors++; $display("FAIL single_busy_idle got=%b want=0", o_busy[12]); end
    endtask

    task automatic test_forced_close();
        do_reset();
        clear_exp();
        for (int k = 8; k <= 14; k++) set_exp(k, (k == 8) ? 3'd7 : 3'd0, 8'(k - 7), 1'b0);
        set_exp(23, 3'd0, 8'd0, 1'b1);
        set_exp(24, 3'd2, 8'd8, 1'b0);
        set_exp(25, 3'd0, 8'd9, 1'b0);
        set_exp(29, 3'd0, 8'd0, 1'b1);
        fork
            capture(31);
            for (int i = 1; i <= 9; i++) write_elem(8'(i), i == 9);
        join
        for (int k = 1; k <= 31; k++) begin
            n_checks++;
            if (o_bus[k] !== e_bus[k]) begin
                n_errors++;
                $display("FAIL forced_bus cycle=%0d got=%03h want=%03h (num,din,done)", k, o_bus[k], e_bus[k]);
            end
        end
        n_checks++; if (o_rdy[9] !== 1'b0)   begin n_errors++; $display("FAIL forced_ready_blocked got=%b want=0", o_rdy[9]); end
        n_checks++; if (o_rdy[15] !== 1'b1)  begin n_errors++; $display("FAIL forced_ready_freed got=%b want=1", o_rdy[15]); end
        n_checks++; if (o_busy[30] !== 1'b0) begin n_errors++; $display("FAIL forced_busy_idle got=%b want=0", o_busy[30]); end
    endtask

    task automatic test_back_to_back();
        logic exp_rdy [3:10];
        exp_rdy = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        do_reset();
        clear_exp();
        set_exp(3, 3'd2, 8'd5, 1'b0);
        set_exp(4, 3'd0, 8'd6, 1'b0);
        set_exp(8, 3'd0, 8'd0, 1'b1);
        set_exp(9, 3'd1, 8'd200, 1'b0);
        set_exp(12, 3'd0, 8'd0, 1'b1);
        set_exp(13, 3'd2, 8'd77, 1'b0);
        set_exp(14, 3'd0, 8'd88, 1'b0);
        set_exp(18, 3'd0, 8'd0, 1'b1);
        fork
            capture(20);
            begin
                write_elem(8'd5, 1'b0);
                write_elem(8'd6, 1'b1);
                write_elem(8'd200, 1'b1);
                write_elem(8'd77, 1'b0);
                write_elem(8'd88, 1'b1);
            end
        join
        for (int k = 1; k <= 20; k++) begin
            n_checks++;
            if (o_bus[k] !== e_bus[k]) begin
                n_errors++;
                $display("FAIL b2b_bus cycle=%0d got=%03h want=%03h (num,din,done)", k, o_bus[k], e_bus[k]);
            end
        end
        for (int k = 3; k <= 10; k++) begin
            n_checks++;
            if (o_rdy[k] !== exp_rdy[k]) begin
                n_errors++;
                $display("FAIL b2b_wr_ready cycle=%0d got=%b want=%b", k, o_rdy[k], exp_rdy[k]);
            end
        end
        n_checks++; if (o_busy[19] !== 1'b0) begin n_errors++; $display("FAIL b2b_busy_idle got=%b want=0", o_busy[19]); end
    endtask

    task automatic test_n1_gap0();
        do_reset();
        clear_exp();
        set_exp(2, 3'd1, 8'd255, 1'b0);
        set_exp(3, 3'd0, 8'd0, 1'b1);
        fork
            capture(5);
            write_elem(8'd255, 1'b1);
        join
        for (int k = 1; k <= 5; k++) begin
            n_checks++;
            if (g_bus[k] !== e_bus[k]) begin
                n_errors++;
                $display("FAIL gap0_bus cycle=%0d got=%03h want=%03h (num,din,done)", k, g_bus[k], e_bus[k]);
            end
        end
        n_checks++; if (g_busy[4] !== 1'b0) begin n_errors++; $display("FAIL gap0_busy_idle got=%b want=0", g_busy[4]); end
    endtask

    task automatic test_reset_mid_send();
        do_reset();
        clear_exp();
        set_exp(7, 3'd6, 8'd11, 1'b0);
        set_exp(8, 3'd0, 8'd12, 1'b0);
        set_exp(9, 3'd0, 8'd13, 1'b0);
        set_exp(10, 3'd0, 8'd14, 1'b0);
        fork
            capture(30);
            begin
                for (int i = 0; i < 6; i++) write_elem(8'(11 + i), i == 5);
                write_elem(8'd21, 1'b0);
                write_elem(8'd22, 1'b1);
            end
            begin
                repeat (10) step();
                rst = 1'b1;
                step();
                rst = 1'b0;
            end
        join
        for (int k = 1; k <= 30; k++) begin
            n_checks++;
            if (o_bus[k] !== e_bus[k]) begin
                n_errors++;
                $display("FAIL rst_send_bus cycle=%0d got=%03h want=%03h (num,din,done)", k, o_bus[k], e_bus[k]);
            end
        end
        n_checks++; if (o_busy[11] !== 1'b0) begin n_errors++; $display("FAIL rst_send_busy got=%b want=0", o_busy[11]); end
        n_checks++; if (o_rdy[11] !== 1'b1)  begin n_errors++; $display("FAIL rst_send_wr_ready got=%b want=1", o_rdy[11]); end
        n_checks++; if (o_busy[30] !== 1'b0) begin n_errors++; $display("FAIL rst_send_busy_late got=%b want=0", o_busy[30]); end
    endtask

    task automatic test_reset_mid_fill();
        do_reset();
        write_elem(8'd31, 1'b0);
        write_elem(8'd32, 1'b0);
        write_elem(8'd33, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++; if (busy !== 1'b0)     begin n_errors++; $display("FAIL rst_fill_busy got=%b want=0", busy); end
        n_checks++; if (wr_ready !== 1'b1) begin n_errors++; $display("FAIL rst_fill_wr_ready got=%b want=1", wr_ready); end
        clear_exp();
        set_exp(2, 3'd1, 8'd7, 1'b0);
        set_exp(5, 3'd0, 8'd0, 1'b1);
        fork
            capture(8);
            write_elem(8'd7, 1'b1);
        join
        for (int k = 1; k <= 8; k++) begin
            n_checks++;
            if (o_bus[k] !== e_bus[k]) begin
                n_errors++;
                $display("FAIL rst_fill_bus cycle=%0d got=%03h want=%03h (num,din,done)", k, o_bus[k], e_bus[k]);
            end
        end
        n_checks++; if (o_busy[6] !== 1'b0) begin n_errors++; $display("FAIL rst_fill_busy_idle got=%b want=0", o_busy[6]); end
    endtask

    initial begin
        repeat (3) step();
        test_reset();
        test_single();
        test_forced_close();
        test_back_to_back();
        test_n1_gap0();
        test_reset_mid_send();
        test_reset_mid_fill();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
